mult_unit: RTL and testbench

//   Multi-cycle 32x32 multiplier for the MIPS EX stage. Executes mult/multu into
//   the HI/LO pair and serves mfhi/mflo reads.
//   It drives multReady, which the hazard detector reads together with multStart
//   and mfReg to stall any mfhi/mflo that is issued while a product is pending.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_shift_add.sv | 56 +++++
 rtl/mult_unit.sv | 109 ++++++++++
 tb/tb_mult_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the multiplier
// Purpose: operand width default, mfhi/mflo select codes and FSM state type
//          used by mult_unit, hazard_detector and the decoder.
// Ports:   none (package).
package mult_pkg;

  // Operand width; HI and LO are each WIDTH bits.
  localparam int WIDTH = 32;

  // mfReg select codes; 2'b11 is reserved and reads as none.
  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_LO   = 2'b01;
  localparam logic [1:0] MF_HI   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SIGN = 2'd2
  } state_t;

endpackage

// File: rtl/mult_shift_add.sv
// rtl/mult_shift_add.sv - radix-2 shift-add datapath for mult_unit
// Purpose: unsigned WIDTH x WIDTH magnitude multiply, one bit per step,
//          multiplier LSB first.
// Ports:   clk, reset          clock, synchronous active-high reset
//          load                capture operands, clear accumulator and counter
//          step                perform one shift-add step
//          mcand_in, mplier_in operand magnitudes
//          acc                 2*WIDTH accumulator
//          done                high while the final step is being taken
module mult_shift_add #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, mcand_in};
      r_mplier <= mplier_in;
      r_count  <= '0;
    end else if (step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  // Asserted during the last of the WIDTH steps so the controller can leave
  // RUN on the same edge that completes the accumulation.
  assign done = (r_count == CW'(WIDTH - 1));
  assign acc  = r_acc;

endmodule

// File: rtl/mult_unit.sv
// rtl/mult_unit.sv - multi-cycle 32x32 mult/multu unit with HI/LO and mfhi/mflo
// Purpose: runs mult/multu over WIDTH+1 cycles into HI/LO and serves reads.
// Ports:   clk, reset   clock, synchronous active-high reset
//          multStart    request a multiply (ignored unless idle)
//          multSigned   1 = mult, 0 = multu
//          srcA, srcB   multiplicand, multiplier
//          mfReg        00 none, 01 mflo, 10 mfhi, 11 none
//          multReady    idle and HI/LO valid
//          mfData       selected HI/LO value, or 0
module mult_unit #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multStart,
  input  logic             multSigned,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [1:0]       mfReg,
  output logic             multReady,
  output logic [WIDTH-1:0] mfData
);

  import mult_pkg::*;

  state_t             r_state;
  logic               r_ready;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_load;
  logic               w_step;
  logic               w_done;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_result;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct unsigned magnitude, so no overflow handling is needed.
  assign w_abs_a = (multSigned && srcA[WIDTH-1]) ? -srcA : srcA;
  assign w_abs_b = (multSigned && srcB[WIDTH-1]) ? -srcB : srcB;

  assign w_load = (r_state == S_IDLE) && multStart;
  assign w_step = (r_state == S_RUN);

  mult_shift_add #(
    .WIDTH(WIDTH)
  ) u_shift_add (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .step      (w_step),
    .mcand_in  (w_abs_a),
    .mplier_in (w_abs_b),
    .acc       (w_acc),
    .done      (w_done)
  );

  assign w_result = r_neg ? -w_acc : w_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (multStart) begin
            r_state <= S_RUN;
            r_ready <= 1'b0;
            r_neg   <= multSigned & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          r_hi    <= w_result[2*WIDTH-1:WIDTH];
          r_lo    <= w_result[WIDTH-1:0];
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign multReady = r_ready;

  always_comb begin
    mfData = '0;
    case (mfReg)
      MF_LO:   mfData = r_lo;
      MF_HI:   mfData = r_hi;
      default: mfData = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb/tb_mult_unit.sv - scoreboard bench for mult_unit
module tb_mult_unit;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic         multStart;
  logic         multSigned;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [1:0]   mfReg;
  logic         multReady;
  logic [W-1:0] mfData;

  mult_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .multStart  (multStart),
    .multSigned (multSigned),
    .srcA       (srcA),
    .srcB       (srcB),
    .mfReg      (mfReg),
    .multReady  (multReady),
    .mfData     (mfData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    int          commit;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;
  int   next_ok = 0;
  bit   rst_seen = 1'b0;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: decides at each edge whether the request is accepted.
  // An accepted request commits LAT edges later; the unit can accept again
  // one edge after that commit.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (reset) begin
        rst_seen = 1'b1;
        q.delete();
        next_ok = edge_n + 1;
      end else begin
        rst_seen = 1'b0;
        if (multStart && edge_n >= next_ok) begin
          q.push_back('{prod: ref_prod(srcA, srcB, multSigned), commit: edge_n + LAT});
          next_ok = edge_n + LAT + 1;
        end
      end
    end
  end

  // Monitor: pops on each multReady rise and checks outputs every cycle.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        prev_ready = 1'b1;
  logic        exp_ready;
  logic [31:0] exp_mf;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        exp_hi = '0;
        exp_lo = '0;
        chk("ready_in_reset", 64'(multReady), 64'd1);
        prev_ready = 1'b1;
      end else begin
        exp_ready = (q.size() == 0) || (q[0].commit <= edge_n);
        chk("multReady", 64'(multReady), 64'(exp_ready));
        if (multReady && !prev_ready) begin
          if (q.size() == 0) begin
            chk("spurious_commit", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("commit_edge", 64'(edge_n), 64'(e.commit));
            exp_hi = e.prod[63:32];
            exp_lo = e.prod[31:0];
          end
        end
        prev_ready = multReady;
      end
      case (mfReg)
        2'b01:   exp_mf = exp_lo;
        2'b10:   exp_mf = exp_hi;
        default: exp_mf = '0;
      endcase
      chk($sformatf("mfData_sel%0d", mfReg), 64'(mfData), 64'(exp_mf));
    end
  end

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mfReg = 2'($urandom_range(0, 3));
      step_cycle();
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    srcA       = a;
    srcB       = b;
    multSigned = s;
    multStart  = 1'b1;
    step_cycle();
    multStart  = 1'b0;
    srcA       = $urandom;
    srcB       = $urandom;
  endtask

  task automatic read_both();
    mfReg = 2'b01;
    step_cycle();
    mfReg = 2'b10;
    step_cycle();
    mfReg = 2'b11;
    step_cycle();
  endtask

  initial begin
    reset      = 1'b1;
    multStart  = 1'b0;
    multSigned = 1'b0;
    srcA       = '0;
    srcB       = '0;
    mfReg      = 2'b01;
    step_cycle();
    mfReg = 2'b10;
    step_cycle();
    step_cycle();
    reset = 1'b0;

    // 3 * 5 unsigned
    start_op(32'd3, 32'd5, 1'b0);
    idle(34);
    read_both();
    // -2 * 3 signed
    start_op(32'hFFFF_FFFE, 32'd3, 1'b1);
    idle(34);
    read_both();
    // all-ones operands, unsigned then signed
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    idle(34);
    read_both();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    idle(34);
    read_both();
    // request while busy is ignored
    start_op(32'd7, 32'd9, 1'b0);
    idle(9);
    start_op(32'd2, 32'd2, 1'b0);
    idle(30);
    read_both();
    // reset mid-operation, then rerun
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    idle(18);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    read_both();
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    idle(34);
    read_both();
    // old LO visible while busy, reserved select reads zero
    start_op(32'd1234, 32'd5678, 1'b0);
    mfReg = 2'b01;
    repeat (20) step_cycle();
    mfReg = 2'b11;
    repeat (16) step_cycle();
    read_both();
    // held request: back-to-back operations with changing operands
    multStart = 1'b1;
    for (int i = 0; i < 75; i++) begin
      srcA       = $urandom;
      srcB       = $urandom;
      multSigned = 1'($urandom_range(0, 1));
      mfReg      = 2'($urandom_range(0, 3));
      step_cycle();
    end
    multStart = 1'b0;
    idle(36);
    // random operations with random gaps, some landing while busy
    for (int i = 0; i < 25; i++) begin
      start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 40));
    end
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      idle(1);
    end
    chk("drain", 64'(q.size()), 64'd0);
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
